// File: rtl/tribus_arb_if.sv
// Channel-side signal bundle for tribus_arb: requests and data in, grant status out.
// The shared tri-state bus itself stays a plain net on the arbiter so it resolves with other drivers.
interface tribus_arb_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int OW = $clog2(NCH);

    // Handshake: a channel holds req[i] high for as long as it wants the bus. gnt[i]
    // (registered) marks the cycles in which data slice i is on the bus, and valid
    // qualifies the bus as a whole. Dropping req releases the bus after the next edge.
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] data;
    logic [NCH-1:0]       gnt;
    logic [OW-1:0]        owner;
    logic                 valid;
    logic [1:0]           dbg_state;

    modport master (
        output req, data,
        input  gnt, owner, valid, dbg_state
    );

    modport slave (
        input  req, data,
        output gnt, owner, valid, dbg_state
    );
endinterface

// File: rtl/tribus_arb.sv
// Round-robin owner of a shared tri-state bus. Exactly one channel drives at a time, and a
// one-cycle high-impedance turnaround always separates two different owners.
module tribus_arb #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    tribus_arb_if.slave       bus,
    output tri [WIDTH-1:0]    y
);
    localparam int OW = $clog2(NCH);
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [NCH-1:0] gnt_q,   gnt_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic           pick_found;
    logic [OW-1:0]  pick_idx;
    logic [NCH-1:0] pick_oh;
    logic [NCH-1:0] owner_oh;
    logic           others_req;

    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int off);
        return OW'((int'(base) + off) % NCH);
    endfunction

    // Scan from the farthest offset down so the nearest requester after owner wins;
    // the owner itself (offset NCH) has the lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner_q;
        for (int i = NCH; i >= 1; i--) begin
            if (bus.req[rr_idx(owner_q, i)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_idx(owner_q, i);
            end
        end
        pick_oh    = {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
        owner_oh   = {{(NCH-1){1'b0}}, 1'b1} << owner_q;
        others_req = |(bus.req & ~owner_oh);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (pick_found) begin
                    state_d = ST_DRIVE;
                    owner_d = pick_idx;
                    gnt_d   = pick_oh;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (!bus.req[owner_q]) begin
                    state_d = others_req ? ST_TURN : ST_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    if (others_req) begin
                        state_d = ST_TURN;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end else begin
                        // Sole requester keeps the bus; restart its hold window.
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OW'(NCH - 1);
            gnt_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.valid     = valid_q;
    assign bus.dbg_state = state_q;

    // Data path is deliberately combinational so the bus tracks the owner's data within the cycle.
    assign y = valid_q ? bus.data[owner_q*WIDTH +: WIDTH] : {WIDTH{1'bz}};
endmodule

// File: tb/tb_tribus_arb.sv
// Directed bench for tribus_arb (WIDTH=8, NCH=4, HOLD_MAX=4): vector table plus
// hand-written rotation, saturation and same-cycle data sequences.
module tb_tribus_arb;
    localparam int WIDTH    = 8;
    localparam int NCH      = 4;
    localparam int HOLD_MAX = 4;

    logic clk;
    logic rst;
    tri [WIDTH-1:0] y;

    tribus_arb_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    tribus_arb #(.WIDTH(WIDTH), .NCH(NCH), .HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .y   (y)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        valid;
        logic [7:0]  y;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D0 = 32'h44_A5_22_11;
    localparam logic [31:0] D1 = 32'h44_3C_22_11;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic [3:0] rq, input logic [31:0] d);
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.data = d;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, D0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- comparisons ----------------
    task automatic check_out(input string nm, input logic [3:0] eg, input logic [1:0] eo,
                             input logic ev, input logic [7:0] ey);
        logic [7:0] zv;
        logic       undriven;
        zv       = 'z;
        undriven = (y === zv) || (y === 8'h00);
        checks++;
        if (bus.gnt !== eg) begin
            failures++;
            $display("FAIL %s gnt got=%b exp=%b", nm, bus.gnt, eg);
        end
        checks++;
        if (bus.owner !== eo) begin
            failures++;
            $display("FAIL %s owner got=%0d exp=%0d", nm, bus.owner, eo);
        end
        checks++;
        if (bus.valid !== ev) begin
            failures++;
            $display("FAIL %s valid got=%b exp=%b", nm, bus.valid, ev);
        end
        checks++;
        if (ev && (y !== ey)) begin
            failures++;
            $display("FAIL %s y got=%h exp=%h", nm, y, ey);
        end else if (!ev && !undriven) begin
            failures++;
            $display("FAIL %s y got=%h exp=zz", nm, y);
        end
        checks++;
        if (bus.valid !== (|bus.gnt) || !$onehot0(bus.gnt)) begin
            failures++;
            $display("FAIL %s invariant gnt=%b valid=%b", nm, bus.gnt, bus.valid);
        end
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic [3:0] rq,
                                input logic [31:0] d, input logic [3:0] g, input logic [1:0] o,
                                input logic v, input logic [7:0] yy);
        vec_t t;
        t.name = n; t.rst = r; t.req = rq; t.data = d;
        t.gnt = g; t.owner = o; t.valid = v; t.y = yy;
        return t;
    endfunction

    // ---------------- test ----------------
    initial begin
        rst      = 1'b1;
        bus.req  = 4'b1111;
        bus.data = D0;

        vecs.push_back(mk("rst_hold0",    1, 4'b1111, D0, 4'b0000, 2'd3, 0, 8'h00));
        vecs.push_back(mk("rst_hold1",    1, 4'b1111, D0, 4'b0000, 2'd3, 0, 8'h00));
        vecs.push_back(mk("rst_release",  0, 4'b1111, D0, 4'b0001, 2'd0, 1, 8'h11));
        vecs.push_back(mk("rst_again",    1, 4'b0000, D0, 4'b0000, 2'd3, 0, 8'h00));
        vecs.push_back(mk("single_grant", 0, 4'b0100, D0, 4'b0100, 2'd2, 1, 8'hA5));
        vecs.push_back(mk("single_data",  0, 4'b0100, D1, 4'b0100, 2'd2, 1, 8'h3C));
        vecs.push_back(mk("single_drop",  0, 4'b0000, D1, 4'b0000, 2'd2, 0, 8'h00));
        vecs.push_back(mk("sim_reset",    1, 4'b0000, D0, 4'b0000, 2'd3, 0, 8'h00));
        vecs.push_back(mk("sim_first",    0, 4'b0011, D0, 4'b0001, 2'd0, 1, 8'h11));
        vecs.push_back(mk("sim_hold",     0, 4'b0011, D0, 4'b0001, 2'd0, 1, 8'h11));
        vecs.push_back(mk("sim_turn",     0, 4'b0010, D0, 4'b0000, 2'd0, 0, 8'h00));
        vecs.push_back(mk("sim_next",     0, 4'b0010, D0, 4'b0010, 2'd1, 1, 8'h22));
        vecs.push_back(mk("swap_turn",    0, 4'b0100, D0, 4'b0000, 2'd1, 0, 8'h00));
        vecs.push_back(mk("swap_next",    0, 4'b0100, D0, 4'b0100, 2'd2, 1, 8'hA5));
        vecs.push_back(mk("mid_reset",    1, 4'b0100, D0, 4'b0000, 2'd3, 0, 8'h00));
        vecs.push_back(mk("mid_release",  0, 4'b0100, D0, 4'b0100, 2'd2, 1, 8'hA5));
        vecs.push_back(mk("pulse_turn",   0, 4'b0001, D0, 4'b0000, 2'd2, 0, 8'h00));
        vecs.push_back(mk("pulse_exit",   0, 4'b1000, D0, 4'b1000, 2'd3, 1, 8'h44));
        vecs.push_back(mk("pulse_idle",   0, 4'b0000, D0, 4'b0000, 2'd3, 0, 8'h00));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].data);
            @(posedge clk);
            #1;
            check_out(vecs[i].name, vecs[i].gnt, vecs[i].owner, vecs[i].valid, vecs[i].y);
        end

        // y follows a data change within the same cycle while ch2 owns the bus.
        drive(1'b0, 4'b0100, D0);
        @(posedge clk);
        #1;
        check_out("comb_before", 4'b0100, 2'd2, 1'b1, 8'hA5);
        bus.data = D1;
        #1;
        check_out("comb_after", 4'b0100, 2'd2, 1'b1, 8'h3C);

        // Forced rotation: ch0 x4, gap, ch3 x4, gap, repeating.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            case (k % 10)
                0, 1, 2, 3:    exp_q.push_back(4'b0001);
                5, 6, 7, 8:    exp_q.push_back(4'b1000);
                default:       exp_q.push_back(4'b0000);
            endcase
        end
        drive(1'b0, 4'b1001, D0);
        for (int k = 0; k < 15; k++) begin
            logic [3:0] eg;
            logic [1:0] eo;
            @(posedge clk);
            #1;
            eg = exp_q.pop_front();
            eo = ((k % 10) <= 4) ? 2'd0 : 2'd3;
            check_out($sformatf("rotate_%0d", k), eg, eo, |eg,
                      (eg == 4'b0001) ? 8'h11 : 8'h44);
        end

        // Sole requester keeps the bus past HOLD_MAX without any gap.
        do_reset();
        drive(1'b0, 4'b0010, D0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("sole_%0d", k), 4'b0010, 2'd1, 1'b1, 8'h22);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
